// File: rtl/alu_req_scheduler.sv
// Round-robin front end for a shared ALU: accepts one operation at a time from two
// requesters, issues it, captures the result after a fixed latency and holds it for display.
module alu_req_scheduler #(
  parameter int ALU_LAT     = 2,
  parameter int HOLD_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [11:0] req0_x,
  input  logic [11:0] req0_y,
  input  logic [2:0]  req0_op,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [11:0] req1_x,
  input  logic [11:0] req1_y,
  input  logic [2:0]  req1_op,
  output logic        req1_ready,
  output logic [12:0] alu_x,
  output logic [12:0] alu_y,
  output logic [2:0]  alu_opcode,
  output logic        alu_start,
  input  logic [12:0] alu_result,
  input  logic        alu_status,
  output logic [11:0] disp_value,
  output logic        disp_valid,
  output logic        disp_owner,
  output logic        ovf,
  output logic        zero,
  output logic        err,
  output logic        done,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  localparam logic [3:0]  LAT_LOAD  = 4'(ALU_LAT - 1);
  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic [2:0]  op_q, op_d;
  logic        owner_q, owner_d;
  logic        alu_start_q, alu_start_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [11:0] disp_value_q, disp_value_d;
  logic        disp_valid_q, disp_valid_d;
  logic        disp_owner_q, disp_owner_d;
  logic        ovf_q, ovf_d, zero_q, zero_d, err_q, err_d, done_q, done_d;

  logic        any_valid, grant_id, accept, div_zero;
  logic [11:0] sel_x, sel_y;
  logic [2:0]  sel_op;

  // prio_q names the requester that wins a tie; it starts at req0 and flips to
  // the other requester after every grant.
  assign any_valid  = req0_valid | req1_valid;
  assign grant_id   = (req0_valid && req1_valid) ? prio_q : req1_valid;
  assign accept     = (state_q == IDLE) && any_valid;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;
  assign sel_x      = grant_id ? req1_x  : req0_x;
  assign sel_y      = grant_id ? req1_y  : req0_y;
  assign sel_op     = grant_id ? req1_op : req0_op;
  assign div_zero   = ((sel_op == 3'b011) || (sel_op == 3'b100)) && (sel_y == 12'd0);

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    x_d          = x_q;
    y_d          = y_q;
    op_d         = op_q;
    owner_d      = owner_q;
    alu_start_d  = 1'b0;
    lat_cnt_d    = lat_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    disp_value_d = disp_value_q;
    disp_valid_d = disp_valid_q;
    disp_owner_d = disp_owner_q;
    ovf_d        = ovf_q;
    zero_d       = zero_q;
    err_d        = err_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          x_d     = sel_x;
          y_d     = sel_y;
          op_d    = sel_op;
          owner_d = grant_id;
          prio_d  = ~grant_id;
          if (div_zero) begin
            // Division by zero never reaches the ALU; report it straight away.
            state_d      = HOLD;
            err_d        = 1'b1;
            disp_value_d = 12'd0;
            ovf_d        = 1'b0;
            zero_d       = 1'b0;
            done_d       = 1'b1;
            disp_valid_d = 1'b1;
            disp_owner_d = grant_id;
            hold_cnt_d   = HOLD_LOAD;
          end else begin
            state_d     = ISSUE;
            alu_start_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        lat_cnt_d = LAT_LOAD;
        state_d   = WAIT;
      end
      WAIT: begin
        if (lat_cnt_q == 4'd0) begin
          state_d      = HOLD;
          disp_value_d = alu_result[11:0];
          ovf_d        = alu_result[12];
          zero_d       = alu_status;
          err_d        = 1'b0;
          done_d       = 1'b1;
          disp_valid_d = 1'b1;
          disp_owner_d = owner_q;
          hold_cnt_d   = HOLD_LOAD;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (hold_cnt_q == 16'd0) begin
          state_d      = IDLE;
          disp_valid_d = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      op_q         <= '0;
      owner_q      <= 1'b0;
      alu_start_q  <= 1'b0;
      lat_cnt_q    <= '0;
      hold_cnt_q   <= '0;
      disp_value_q <= '0;
      disp_valid_q <= 1'b0;
      disp_owner_q <= 1'b0;
      ovf_q        <= 1'b0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      x_q          <= x_d;
      y_q          <= y_d;
      op_q         <= op_d;
      owner_q      <= owner_d;
      alu_start_q  <= alu_start_d;
      lat_cnt_q    <= lat_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      disp_value_q <= disp_value_d;
      disp_valid_q <= disp_valid_d;
      disp_owner_q <= disp_owner_d;
      ovf_q        <= ovf_d;
      zero_q       <= zero_d;
      err_q        <= err_d;
      done_q       <= done_d;
    end
  end

  assign alu_x      = {1'b0, x_q};
  assign alu_y      = {1'b0, y_q};
  assign alu_opcode = op_q;
  assign alu_start  = alu_start_q;
  assign disp_value = disp_value_q;
  assign disp_valid = disp_valid_q;
  assign disp_owner = disp_owner_q;
  assign ovf        = ovf_q;
  assign zero       = zero_q;
  assign err        = err_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler: a stand-in ALU with exact latency, and a
// scoreboard filled on every accept and drained on every done pulse.
module tb_alu_req_scheduler;
  localparam int ALU_LAT     = 2;
  localparam int HOLD_CYCLES = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [11:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic        req0_ready, req1_ready;
  logic [12:0] alu_x, alu_y, alu_result;
  logic [2:0]  alu_opcode;
  logic        alu_start, alu_status;
  logic [11:0] disp_value;
  logic        disp_valid, disp_owner, ovf, zero, err, done, busy;

  alu_req_scheduler #(.ALU_LAT(ALU_LAT), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_op(req1_op), .req1_ready(req1_ready),
    .alu_x(alu_x), .alu_y(alu_y), .alu_opcode(alu_opcode), .alu_start(alu_start),
    .alu_result(alu_result), .alu_status(alu_status),
    .disp_value(disp_value), .disp_valid(disp_valid), .disp_owner(disp_owner),
    .ovf(ovf), .zero(zero), .err(err), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        owner;
    logic [11:0] val;
    logic        ovf;
    logic        zero;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0, fails = 0;
  int          cyc = 0;
  int          start_exp_cyc = -1;
  logic [38:0] start_exp_ops;
  int          run = 0;
  logic [15:0] pipe = '0;
  logic [12:0] alu_res = '0;

  function automatic logic [12:0] alu_fn(input logic [11:0] x, input logic [11:0] y, input logic [2:0] op);
    logic [12:0] a, b;
    a = {1'b0, x};
    b = {1'b0, y};
    case (op)
      3'd0: return a;
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return (b == 0) ? 13'd0 : a / b;
      3'd4: return (b == 0) ? 13'd0 : a % b;
      3'd5: return (a > b) ? a : b;
      3'd6: return a >> b;
      default: return a << b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stand-in ALU: the result is only correct in the single cycle the scheduler should sample it.
  assign alu_result = pipe[ALU_LAT-1] ? alu_res : ~alu_res;
  assign alu_status = pipe[ALU_LAT-1] ? (alu_res == 13'd0) : (alu_res != 13'd0);

  always @(posedge clk) begin
    logic        id;
    logic [11:0] x, y;
    logic [2:0]  op;
    logic [12:0] r;
    exp_t        e;
    cyc = cyc + 1;
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe <= {pipe[14:0], alu_start};
      if (alu_start) alu_res <= alu_fn(alu_x[11:0], alu_y[11:0], alu_opcode);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        id = req1_valid && req1_ready;
        x  = id ? req1_x : req0_x;
        y  = id ? req1_y : req0_y;
        op = id ? req1_op : req0_op;
        e.owner = id;
        e.err   = (op == 3'd3 || op == 3'd4) && (y == 12'd0);
        r       = alu_fn(x, y, op);
        e.val   = e.err ? 12'd0 : r[11:0];
        e.ovf   = e.err ? 1'b0 : r[12];
        e.zero  = e.err ? 1'b0 : (r == 13'd0);
        e.cyc   = e.err ? cyc : cyc + ALU_LAT + 1;
        sb.push_back(e);
        start_exp_cyc = e.err ? -1 : cyc;
        start_exp_ops = {1'b0, x, 1'b0, y, op};
        $display("[TB] accept req%0d x=%0d y=%0d op=%0d at cycle %0d", id, x, y, op, cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      start_exp_cyc = -1;
      run = 0;
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          check("done_spurious", 64'(done), 64'd0);
        end else begin
          e = sb.pop_front();
          $display("[TB] done owner=%0d value=%0h ovf=%0d zero=%0d err=%0d at cycle %0d",
                   disp_owner, disp_value, ovf, zero, err, cyc);
          check("done_cycle", 64'(cyc), 64'(e.cyc));
          check("disp_value", 64'(disp_value), 64'(e.val));
          check("disp_owner", 64'(disp_owner), 64'(e.owner));
          check("ovf", 64'(ovf), 64'(e.ovf));
          check("zero", 64'(zero), 64'(e.zero));
          check("err", 64'(err), 64'(e.err));
          check("disp_valid_at_done", 64'(disp_valid), 64'd1);
        end
      end
      if (alu_start || cyc == start_exp_cyc) begin
        check("alu_start_cycle", 64'(cyc), 64'(start_exp_cyc));
        check("alu_start_level", 64'(alu_start), 64'd1);
        check("alu_operands", 64'({alu_x, alu_y, alu_opcode}), 64'(start_exp_ops));
        start_exp_cyc = -1;
      end
      if (busy) check("ready_low_while_busy", 64'({req0_ready, req1_ready}), 64'd0);
      if (disp_valid) begin
        run++;
      end else if (run != 0) begin
        check("disp_valid_length", 64'(run), 64'(HOLD_CYCLES));
        run = 0;
      end
    end
  end

  task automatic issue(input bit id, input logic [11:0] x, input logic [11:0] y, input logic [2:0] op);
    bit got = 1'b0;
    if (!id) begin
      req0_x = x; req0_y = y; req0_op = op; req0_valid = 1'b1;
    end else begin
      req1_x = x; req1_y = y; req1_op = op; req1_valid = 1'b1;
    end
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      got = id ? req1_ready : req0_ready;
    end
    check("accept_timeout", 64'(got), 64'd1);
    #1;
    if (!id) req0_valid = 1'b0;
    else     req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    int          rr_exp[4];
    logic [11:0] r0x[2], r0y[2], r1x[2], r1y[2];
    logic [2:0]  r0op[2], r1op[2];
    int          n, i0, i1, g;
    rr_exp = '{0, 1, 0, 1};
    r0x = '{12'd10, 12'd300};  r0y = '{12'd20, 12'd3};  r0op = '{3'd1, 3'd3};
    r1x = '{12'd40, 12'd9};    r1y = '{12'd2, 12'd4};   r1op = '{3'd7, 3'd5};

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'({alu_x, alu_y, alu_opcode, alu_start, disp_value, disp_valid,
                                disp_owner, ovf, zero, err, done, busy, req0_ready, req1_ready}), 64'd0);
    reset = 1'b0;

    issue(1'b0, 12'd100, 12'd23, 3'd1);
    wait_idle();
    check("add_value", 64'(disp_value), 64'd123);
    check("add_owner", 64'(disp_owner), 64'd0);
    check("persist_after_hold", 64'({disp_valid, ovf, err}), 64'd0);

    issue(1'b1, 12'd50, 12'd0, 3'd3);
    wait_idle();
    check("div0_err", 64'({err, disp_value, disp_owner}), 64'({1'b1, 12'd0, 1'b1}));

    issue(1'b1, 12'd50, 12'd7, 3'd4);
    wait_idle();
    check("mod_value", 64'({err, disp_value}), 64'({1'b0, 12'd1}));

    issue(1'b0, 12'd5, 12'd9, 3'd2);
    wait_idle();
    check("wrap_value", 64'({ovf, disp_value}), 64'({1'b1, 12'hFFC}));

    issue(1'b0, 12'd7, 12'd7, 3'd2);
    req1_x = 12'd1; req1_y = 12'd1; req1_op = 3'd1; req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 req1_valid = 1'b0;
    wait_idle();
    check("zero_flag", 64'({zero, disp_value}), 64'({1'b1, 12'd0}));
    repeat (6) @(negedge clk);
    check("dropped_valid_ignored", 64'(busy), 64'd0);

    @(posedge clk); #1;
    issue(1'b0, 12'd2048, 12'd1, 3'd7);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", 64'({alu_x, alu_y, alu_opcode, alu_start, disp_value, disp_valid,
                                      disp_owner, ovf, zero, err, done, busy}), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    issue(1'b0, 12'd2048, 12'd1, 3'd7);
    wait_idle();
    check("shl_value", 64'({ovf, zero, disp_value}), 64'({1'b1, 1'b0, 12'd0}));

    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    req0_x = r0x[0]; req0_y = r0y[0]; req0_op = r0op[0]; req0_valid = 1'b1;
    req1_x = r1x[0]; req1_y = r1y[0]; req1_op = r1op[0]; req1_valid = 1'b1;
    n = 0; i0 = 0; i1 = 0;
    for (int c = 0; c < 600 && n < 4; c++) begin
      @(posedge clk);
      g = (req0_valid && req0_ready) ? 0 : ((req1_valid && req1_ready) ? 1 : -1);
      if (g >= 0) begin
        check("rr_grant", 64'(g), 64'(rr_exp[n]));
        n++;
        #1;
        if (g == 0) begin
          i0++;
          if (i0 < 2) begin req0_x = r0x[i0]; req0_y = r0y[i0]; req0_op = r0op[i0]; end
          else req0_valid = 1'b0;
        end else begin
          i1++;
          if (i1 < 2) begin req1_x = r1x[i1]; req1_y = r1y[i1]; req1_op = r1op[i1]; end
          else req1_valid = 1'b0;
        end
      end
    end
    check("rr_count", 64'(n), 64'd4);
    wait_idle();
    check("rr_last_result", 64'({disp_owner, disp_value}), 64'({1'b1, 12'd9}));
    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
- Shares the single ALU datapath between two requesters (req0, req1) using round-robin arbitration.
- Sequences each accepted operation: issues it to the ALU, waits a fixed latency, captures the 13-bit result, then holds the low 12 bits stable for the BCD converter / 7-segment scan path for a programmable number of cycles.
- Detects divide/modulo by zero and short-circuits the ALU.
- Sits between operand sources (switch banks, test sequencer) and the ALU + display chain.

Parameters:
- ALU_LAT, 2, cycles from alu_start to a valid alu_result; legal range 1..15.
- HOLD_CYCLES, 8, cycles disp_valid stays high per result; legal range 1..65535.

Ports:
- clk  in  1  single system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_x  in  12  operand x.
- req0_y  in  12  operand y.
- req0_op  in  3  ALU opcode (000 pass x, 001 add, 010 sub, 011 div, 100 mod, 101 max, 110 shr, 111 shl).
- req0_ready  out  1  combinational; the transfer happens on a posedge where valid&&ready.
- req1_valid, req1_x, req1_y, req1_op, req1_ready: same as req0.
- alu_x  out  13  {1'b0, captured x}.
- alu_y  out  13  {1'b0, captured y}.
- alu_opcode  out  3  captured opcode.
- alu_start  out  1  one-cycle issue pulse.
- alu_result  in  13  ALU result.
- alu_status  in  1  ALU zero flag.
- disp_value  out  12  result to the BCD converter.
- disp_valid  out  1  high during HOLD.
- disp_owner  out  1  id of the requester owning disp_value.
- ovf  out  1  alu_result[12] of the last result.
- zero  out  1  alu_status of the last result.
- err  out  1  last operation was div/mod by zero.
- done  out  1  one-cycle pulse when a result is captured.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE; rr pointer = 0 (req0 wins the first tie).
  - All outputs are 0, including the registered alu_* outputs, disp_*, ovf, zero, err, done.
  - The op counter and hold counter clear.
  - An in-flight operation is dropped with no done pulse.
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - readyN = (state==IDLE) && selected(N). Selection:
    - only one valid: grant that one;
    - both valid: grant the requester != last_grant;
    - none valid: ready low.
  - On the accepting edge: capture x, y, op, owner; update last_grant.
  - If op is 011 or 100 and y==0: go to HOLD with err=1, disp_value=0, ovf=0, zero=0, done=1, and alu_start never asserted.
  - Otherwise go to ISSUE.
- ISSUE:
  - alu_start=1 for exactly one cycle.
  - alu_x/alu_y/alu_opcode come from captured registers and stay stable until the next accept.
  - Counter loads ALU_LAT-1; next state WAIT.
- WAIT:
  - Counter decrements each cycle.
  - On the edge ending the WAIT cycle with counter==0 (ALU_LAT cycles after ISSUE): sample alu_result/alu_status.
  - At that edge: disp_value=alu_result[11:0], ovf=alu_result[12], zero=alu_status, err=0, done=1 (the following cycle), go to HOLD.
- HOLD:
  - disp_valid=1 for exactly HOLD_CYCLES cycles, then IDLE.
  - readyN stays low throughout; pending valids wait.
- Latency: the accept edge is at t0; the ISSUE cycle is t0+1; done/disp_valid first go high at cycle t0+2+ALU_LAT.
- Error path: done and disp_valid rise at t0+1.
- After HOLD: disp_value, disp_owner, ovf, zero and err persist; disp_valid drops.
- done is high only in the first HOLD cycle.
- Back-to-back requests: at least 1 IDLE cycle between HOLD end and the next accept. Requesters hold valid and data stable until ready.
- Sub with x<y: the 13-bit wrap sets ovf=1; disp_value is the raw low 12 bits (no clamp).
- A valid that drops before ready is not served and is not latched.

Test Plan:
- Single op: req0 x=100, y=23, op=001, ALU_LAT=2, HOLD_CYCLES=8 → alu_start 1 cycle after accept; disp_value=123, ovf=0, done at t0+4, disp_valid high 8 cycles, disp_owner=0.
- Round-robin: req0 and req1 both valid continuously → grants 0,1,0,1. Each operation's values appear in order with the matching disp_owner, and the other requester's ready is never high during busy.
- Divide by zero: req1 x=50, y=0, op=011 → alu_start stays 0; err=1, disp_value=0, done at t0+1. Then req1 x=50, y=7, op=100 → disp_value=1, err=0.
- Wrap: x=5, y=9, op=010 → alu_result=13'h1FFC; disp_value=12'hFFC, ovf=1.
- Zero flag: x=7, y=7, op=010 → disp_value=0, zero=1.
- Async reset asserted mid-WAIT → all outputs 0 immediately with no done. After release, a new req0 op=111 x=2048 gives disp_value=0, ovf=1, zero=0 (ALU status reflects the full 13-bit value).
